pwm_multichannel: RTL and testbench

Parametrised multi-channel PWM generator, the successor to the single-channel fixed-width PWM block. It adds a shared programmable period, per-channel duty registers behind a write port, and a 2^speed clock prescaler. It also adds edge- or center-aligned counting and shadowed, glitch-free updates applied only at period boundaries. It sits behind the top-level pin wrapper, driving `pwm` onto dedicated outputs, with configuration written from a host or input pins.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_prescaler.sv | 48 ++++
 rtl/pwm_multichannel.sv | 171 +++++++++++++++++
 tb/tb_pwm_multichannel.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
//   pwm_mode_e : counting style (edge-aligned sawtooth or center-aligned triangle)
//   pwm_dir_e  : center-mode count direction
//   ADDR_PERIOD / ADDR_MODE : config-port addresses that follow the duty bank
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Period register sits directly after the per-channel duty registers.
  function automatic int unsigned ADDR_PERIOD(input int unsigned channels);
    return channels;
  endfunction

  // Mode register sits directly after the period register.
  function automatic int unsigned ADDR_MODE(input int unsigned channels);
    return channels + 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: asserts tick once every 2^speed clocks while enabled.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   enable : run; low holds the divider at 0 and suppresses tick
//   speed  : log2 of the division ratio
//   tick   : combinational one-clock strobe, high in the clock the divider
//            reaches its limit
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] speed,
  output logic                  tick
);

  // Wide enough to hold the largest limit 2^(2^PRESCALE_W - 1) - 1.
  localparam int unsigned CW = (1 << PRESCALE_W) - 1;
  localparam logic [CW-1:0] ONES = '1;

  logic [CW-1:0] pre_cnt_q;
  logic [CW-1:0] pre_cnt_d;
  logic [CW-1:0] limit_c;
  logic          at_limit_c;

  // Limit is 2^speed - 1; >= lets a lowered speed wrap immediately.
  always_comb begin
    limit_c    = ~(ONES << speed);
    at_limit_c = (pre_cnt_q >= limit_c);
    pre_cnt_d  = pre_cnt_q + CW'(1);
    if (!enable || at_limit_c) begin
      pre_cnt_d = '0;
    end
    tick = enable && at_limit_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator with shared period, per-channel duty,
// prescaled edge- or center-aligned counter and shadowed config that is
// committed only at period boundaries.
//   clk, rst     : clock and synchronous active-high reset
//   enable       : run; low idles the counter and forces outputs low
//   speed        : prescaler select, counter ticks every 2^speed clocks
//   wr_en        : config write strobe
//   wr_addr      : 0..CHANNELS-1 duty, CHANNELS period, CHANNELS+1 mode
//   wr_data      : write data (mode uses bit 0)
//   pwm          : registered per-channel PWM outputs
//   period_start : one-clock pulse in the clock the counter restarts at 0
//   cnt_out      : current counter value
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned PRESCALE_W = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [PRESCALE_W-1:0]          speed,
  input  logic                           wr_en,
  input  logic [$clog2(CHANNELS+2)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [CHANNELS-1:0]            pwm,
  output logic                           period_start,
  output logic [WIDTH-1:0]               cnt_out
);

  localparam int unsigned AW     = $clog2(CHANNELS + 2);
  localparam int unsigned A_PER  = ADDR_PERIOD(CHANNELS);
  localparam int unsigned A_MODE = ADDR_MODE(CHANNELS);

  // Shadow bank (host-visible) and active bank (used by the counter).
  logic [CHANNELS-1:0][WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [CHANNELS-1:0][WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0]               period_sh_q, period_sh_d;
  logic [WIDTH-1:0]               period_act_q, period_act_d;
  pwm_mode_e                      mode_sh_q, mode_sh_d;
  pwm_mode_e                      mode_act_q, mode_act_d;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  pwm_dir_e            dir_q, dir_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q, period_start_d;

  logic                tick;
  logic [WIDTH-1:0]    cnt_step_c;
  pwm_dir_e            dir_step_c;
  logic                boundary_c;

  pwm_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .speed  (speed),
    .tick   (tick)
  );

  // Counter value the next tick would produce under the active mode/period.
  always_comb begin
    cnt_step_c = cnt_q;
    dir_step_c = dir_q;
    if (mode_act_q == PWM_EDGE) begin
      dir_step_c = DIR_UP;
      cnt_step_c = (cnt_q >= period_act_q) ? '0 : cnt_q + WIDTH'(1);
    end else if (period_act_q == '0) begin
      dir_step_c = DIR_UP;
      cnt_step_c = '0;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= period_act_q) begin
        cnt_step_c = period_act_q - WIDTH'(1);
        dir_step_c = DIR_DOWN;
      end else begin
        cnt_step_c = cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_step_c = (cnt_q == '0) ? '0 : cnt_q - WIDTH'(1);
    end
  end

  // A boundary is exactly the tick that returns the counter to 0.
  assign boundary_c = tick && (cnt_step_c == '0);

  // Config writes, counter advance and shadow-to-active commit.
  always_comb begin
    duty_sh_d      = duty_sh_q;
    period_sh_d    = period_sh_q;
    mode_sh_d      = mode_sh_q;
    duty_act_d     = duty_act_q;
    period_act_d   = period_act_q;
    mode_act_d     = mode_act_q;
    cnt_d          = cnt_q;
    dir_d          = dir_q;
    period_start_d = 1'b0;

    if (wr_en) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wr_addr == AW'(i)) begin
          duty_sh_d[i] = wr_data;
        end
      end
      if (wr_addr == AW'(A_PER)) begin
        period_sh_d = wr_data;
      end
      if (wr_addr == AW'(A_MODE)) begin
        mode_sh_d = pwm_mode_e'(wr_data[0]);
      end
    end

    // Commit reads the pre-write shadow, so a write landing in a boundary
    // clock waits for the following boundary.
    if (!enable) begin
      cnt_d        = '0;
      dir_d        = DIR_UP;
      duty_act_d   = duty_sh_q;
      period_act_d = period_sh_q;
      mode_act_d   = mode_sh_q;
    end else if (tick) begin
      cnt_d = cnt_step_c;
      dir_d = dir_step_c;
      if (boundary_c) begin
        duty_act_d     = duty_sh_q;
        period_act_d   = period_sh_q;
        mode_act_d     = mode_sh_q;
        dir_d          = DIR_UP;
        period_start_d = 1'b1;
      end
    end
  end

  // Per-channel comparators on the current counter value.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cmp
    assign pwm_d[gi] = enable && (cnt_q < duty_act_q[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q      <= '0;
      duty_act_q     <= '0;
      period_sh_q    <= '1;
      period_act_q   <= '1;
      mode_sh_q      <= PWM_EDGE;
      mode_act_q     <= PWM_EDGE;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_sh_q      <= duty_sh_d;
      duty_act_q     <= duty_act_d;
      period_sh_q    <= period_sh_d;
      period_act_q   <= period_act_d;
      mode_sh_q      <= mode_sh_d;
      mode_act_q     <= mode_act_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm          = pwm_q;
  assign period_start = period_start_q;
  assign cnt_out      = cnt_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench for pwm_multichannel: stimulus pushes cycle-tagged
// expected outputs, a negedge monitor pops and compares them.
module tb_pwm_multichannel;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CH    = 4;
  localparam int unsigned PW    = 3;
  localparam int unsigned AW    = $clog2(CH + 2);

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [PW-1:0]    speed;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [CH-1:0]    pwm;
  logic             period_start;
  logic [WIDTH-1:0] cnt_out;

  pwm_multichannel #(
    .WIDTH      (WIDTH),
    .CHANNELS   (CH),
    .PRESCALE_W (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .speed        (speed),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pwm          (pwm),
    .period_start (period_start),
    .cnt_out      (cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] cnt;
    logic [CH-1:0]    pwm;
    logic             ps;
    string            tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t me;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Hand-derived expected sequences, entry k = state after the k-th clock.
  // Edge, P=3, duty {1,2,0,5}.
  localparam int T_EDGE_CNT [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  localparam int T_EDGE_PWM [8] = '{'hB, 'hA, 'h8, 'h8, 'hB, 'hA, 'h8, 'h8};
  localparam int T_EDGE_PS  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  // duty0 -> 3 written mid-period, then duty0 -> 2 written in a boundary clock.
  localparam int T_SH_CNT [16] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
  localparam int T_SH_PWM [16] = '{'hB, 'hA, 'h8, 'h8, 'hB, 'hB, 'h9, 'h8,
                                   'hB, 'hB, 'h9, 'h8, 'hB, 'hB, 'h8, 'h8};
  localparam int T_SH_PS  [16] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  // Center, P=4, duty {2,2,0,5}; reset lands in the down-count (entry 14).
  localparam int T_CT_CNT [16] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 0, 1, 2};
  localparam int T_CT_PWM [16] = '{'hB, 'hB, 'h8, 'h8, 'h8, 'h8, 'h8, 'hB,
                                   'hB, 'hB, 'h8, 'h8, 'h8, 'h0, 'h0, 'h0};
  localparam int T_CT_PS  [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  // Edge, P=1, duty0=1, speed 2 then 0; out-of-range writes from entry 15.
  localparam int T_PS_CNT [22] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1,
                                   0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  localparam int T_PS_PWM [22] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1,
                                   0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  localparam int T_PS_PS  [22] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,
                                   1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  always @(posedge clk) cyc++;

  // Monitor: compare every expectation due at or before this cycle.
  always @(negedge clk) begin
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      me = sb_q.pop_front();
      n_vec++;
      if (me.cyc != cyc || cnt_out !== me.cnt || pwm !== me.pwm ||
          period_start !== me.ps) begin
        n_err++;
        $display("FAIL %s cyc %0d (due %0d): cnt_out=%0d want %0d, pwm=%b want %b, period_start=%b want %b",
                 me.tag, cyc, me.cyc, cnt_out, me.cnt, pwm, me.pwm, period_start, me.ps);
      end
    end
  end

  task automatic push(input int c, input int cn, input int p, input int s, input string tag);
    exp_t e;
    e.cyc = c;
    e.cnt = WIDTH'(cn);
    e.pwm = CH'(p);
    e.ps  = 1'(s);
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Drive one write for a single clock; call right after a negedge.
  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = WIDTH'(d);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset with live-looking inputs applied.
    rst     = 1'b1;
    enable  = 1'b1;
    speed   = '0;
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 8'hAA;
    @(negedge clk);
    push(cyc + 1, 0, 0, 0, "reset");
    step(1);
    rst    = 1'b0;
    wr_en  = 1'b0;
    enable = 1'b0;

    // Edge mode, P=3, duty {1,2,0,5}, speed 0.
    wr(0, 1);
    wr(1, 2);
    wr(2, 0);
    wr(3, 5);
    wr(4, 3);
    wr(5, 0);
    step(1);
    base = cyc;
    for (int k = 0; k < 8; k++) push(base + k + 1, T_EDGE_CNT[k], T_EDGE_PWM[k], T_EDGE_PS[k], "edge");
    enable = 1'b1;
    step(8);

    // Shadowing: mid-period write, then write in a boundary clock.
    base = cyc;
    for (int k = 0; k < 16; k++) push(base + k + 1, T_SH_CNT[k], T_SH_PWM[k], T_SH_PS[k], "shadow");
    step(1);
    wr(0, 3);
    step(5);
    wr(0, 2);
    step(8);

    // Enable low forces outputs low on the next clock.
    enable = 1'b0;
    push(cyc + 1, 0, 0, 0, "enable_low");
    step(1);

    // Center mode, P=4, duty0=2; then reset during the down-count.
    wr(4, 4);
    wr(5, 1);
    wr(0, 2);
    step(1);
    base = cyc;
    for (int k = 0; k < 16; k++)
      push(base + k + 1, T_CT_CNT[k], T_CT_PWM[k], T_CT_PS[k], (k < 13) ? "center" : "rst_mid");
    enable = 1'b1;
    step(13);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);

    // Prescaler: speed 2 with P=1, then drop to speed 0 mid-count.
    enable = 1'b0;
    push(cyc + 1, 0, 0, 0, "enable_low2");
    step(1);
    wr(4, 1);
    wr(0, 1);
    speed = 3'd2;
    step(1);
    base = cyc;
    for (int k = 0; k < 22; k++)
      push(base + k + 1, T_PS_CNT[k], T_PS_PWM[k], T_PS_PS[k], (k < 14) ? "prescale" : "bad_addr");
    enable = 1'b1;
    step(10);
    speed = 3'd0;
    step(4);

    // Out-of-range addresses must not touch any register.
    wr(CH + 2, 0);
    wr(CH + 3, 0);
    step(6);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
